// File: rtl/move_list_ctrl.sv
// move_list_ctrl: Avalon-MM controller that kicks a move generator, unpacks its FIFO into a result RAM.
// Optional cycle counter at 0xA built when MOVE_LIST_CTRL_PERF_EN is defined.
module move_list_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int SLOTS = 8,
  parameter int SLOT_W = 18,
  parameter int BOARD_BITS = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_WIDTH-1:0]         slave_address,
  input  logic                          slave_read,
  input  logic                          slave_write,
  input  logic [31:0]                   slave_writedata,
  output logic [31:0]                   slave_readdata,
  output logic                          gen_reset,
  output logic [BOARD_BITS-1:0]         gen_bstate,
  input  logic                          gen_done,
  input  logic                          gen_fifo_empty,
  output logic                          gen_rden,
  input  logic [SLOTS*(SLOT_W+1)-1:0]   gen_fifo_data,
  output logic                          busy
);
  localparam int DEPTH = 2**ADDR_WIDTH - 16;
  localparam int SW = SLOT_W + 1;
  localparam int NW = BOARD_BITS / 32;
  localparam int IW = SLOTS > 1 ? $clog2(SLOTS) : 1;
  localparam logic [15:0] MAX_MOVES = 16'(2**ADDR_WIDTH - 17);

  typedef enum logic [2:0] {IDLE, KICK, WAIT, POP, LATCH, UNPACK, TERM, DONE} state_t;
  state_t state, next;

  logic start_reg, done, overflow;
  logic [15:0] count;
  logic [SLOTS*SW-1:0] slots;
  logic [IW-1:0] sidx;
  logic [BOARD_BITS-1:0] bstate;
  logic [SLOT_W-1:0] ram [DEPTH];
  logic [31:0] rd_val, perf_val;

  logic ctrl_wr, start_wr, stop_wr, slot_ok, last, full, ram_we;
  logic [SLOT_W-1:0] ram_wd;
  logic [ADDR_WIDTH-1:0] ram_idx;

  assign ctrl_wr  = slave_write && slave_address == '0;
  assign start_wr = ctrl_wr && slave_writedata[0];
  assign stop_wr  = ctrl_wr && !slave_writedata[0];
  assign slot_ok  = !slots[SW-1];
  assign last     = sidx == IW'(SLOTS - 1);
  assign full     = count == MAX_MOVES;
  assign busy     = state != IDLE && state != DONE;
  assign gen_reset  = state == KICK;
  assign gen_rden   = state == POP && !gen_fifo_empty && !stop_wr;
  assign gen_bstate = bstate;
  assign ram_we  = !stop_wr && ((state == UNPACK && slot_ok && !full) || state == TERM);
  assign ram_wd  = state == TERM ? '0 : slots[SLOT_W-1:0];
  assign ram_idx = slave_address - ADDR_WIDTH'(16);

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;

  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start_wr ? KICK : IDLE;
      DONE:    next = start_wr ? KICK : stop_wr ? IDLE : DONE;
      KICK:    next = WAIT;
      WAIT:    next = gen_done ? POP : WAIT;
      POP:     next = gen_fifo_empty ? TERM : LATCH;
      LATCH:   next = UNPACK;
      UNPACK:  next = last ? POP : UNPACK;
      TERM:    next = DONE;
      default: next = IDLE;
    endcase
    if (busy && stop_wr) next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_reg <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      count     <= '0;
      slots     <= '0;
      sidx      <= '0;
      bstate    <= '0;
    end else begin
      if (ctrl_wr) start_reg <= slave_writedata[0];
      for (int w = 0; w < NW; w++)
        if (slave_write && slave_address == ADDR_WIDTH'(w + 2)) bstate[w*32 +: 32] <= slave_writedata;
      if (start_wr && !busy) begin
        count    <= '0;
        overflow <= 1'b0;
        done     <= 1'b0;
      end else if (stop_wr) begin
        done <= 1'b0;
      end else begin
        case (state)
          LATCH: begin
            slots <= gen_fifo_data;
            sidx  <= '0;
          end
          UNPACK: begin
            slots <= slots >> SW;
            sidx  <= sidx + 1'b1;
            if (slot_ok && full) overflow <= 1'b1;
            if (slot_ok && !full) count <= count + 1'b1;
          end
          TERM:    done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Slot-wise writes land at RAM[count]; the terminator reuses the same address path.
  always_ff @(posedge clk)
    if (ram_we) ram[count[ADDR_WIDTH-1:0]] <= ram_wd;

`ifdef MOVE_LIST_CTRL_PERF_EN
  logic [31:0] perf;
  always_ff @(posedge clk or posedge reset)
    if (reset) perf <= '0;
    else if (state == KICK) perf <= 32'd1;
    else if (busy && perf != '1) perf <= perf + 1'b1;
  assign perf_val = perf;
`else
  assign perf_val = '0;
`endif

  always_comb begin
    rd_val = '0;
    if (slave_address >= ADDR_WIDTH'(16)) rd_val = 32'(ram[ram_idx]);
    else if (slave_address == ADDR_WIDTH'(0)) rd_val = {30'b0, done, start_reg};
    else if (slave_address == ADDR_WIDTH'(1)) rd_val = {overflow, 15'b0, count};
    else if (slave_address == ADDR_WIDTH'(10)) rd_val = perf_val;
    for (int w = 0; w < NW; w++)
      if (slave_address == ADDR_WIDTH'(w + 2)) rd_val = bstate[w*32 +: 32];
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) slave_readdata <= '0;
    else if (slave_read) slave_readdata <= rd_val;
endmodule

// File: tb/tb_move_list_ctrl.sv
// tb_move_list_ctrl: randomized directed bench for move_list_ctrl against a move-list reference model.
module tb_move_list_ctrl;
  localparam int AW = 6, SL = 8, SW = 18, BB = 256, WW = SL * (SW + 1), MAXM = 2**AW - 17;

  logic clk = 1'b0, reset = 1'b1;
  logic [AW-1:0] addr = '0;
  logic rdv = 1'b0, wrv = 1'b0, gen_done = 1'b0;
  logic [31:0] wdata = '0, readdata;
  logic gen_reset, gen_rden, busy, fifo_empty;
  logic [BB-1:0] gen_bstate;
  logic [WW-1:0] fdata = '0;
  logic [WW-1:0] mem [256];
  int wr_n = 0, rd_n = 0, kicks = 0, pops = 0;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  move_list_ctrl #(.ADDR_WIDTH(AW), .SLOTS(SL), .SLOT_W(SW), .BOARD_BITS(BB)) dut (
    .clk(clk), .reset(reset), .slave_address(addr), .slave_read(rdv), .slave_write(wrv),
    .slave_writedata(wdata), .slave_readdata(readdata), .gen_reset(gen_reset),
    .gen_bstate(gen_bstate), .gen_done(gen_done), .gen_fifo_empty(fifo_empty),
    .gen_rden(gen_rden), .gen_fifo_data(fdata), .busy(busy));

  assign fifo_empty = rd_n == wr_n;

  always @(posedge clk) begin
    if (gen_rden) begin
      fdata <= mem[rd_n[7:0]];
      rd_n  <= rd_n + 1;
      pops  <= pops + 1;
    end
    if (gen_reset) kicks <= kicks + 1;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    @(negedge clk);
    addr = AW'(a);
    rdv = 1'b1;
    @(negedge clk);
    rdv = 1'b0;
    d = readdata;
  endtask

  task automatic wr(input int a, input logic [31:0] v);
    @(negedge clk);
    addr = AW'(a);
    wdata = v;
    wrv = 1'b1;
    @(negedge clk);
    wrv = 1'b0;
  endtask

  task automatic push(input logic [WW-1:0] w);
    mem[wr_n[7:0]] = w;
    wr_n++;
  endtask

  function automatic logic [WW-1:0] rnd_word(input bit all_valid);
    logic [WW-1:0] w;
    for (int s = 0; s < SL; s++)
      w[s*(SW+1) +: SW+1] = {all_valid ? 1'b0 : ($urandom_range(0, 2) == 0), SW'($urandom)};
    return w;
  endfunction

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk({tag, " timeout"}, busy, 0);
  endtask

  task automatic run(input int dly, input string tag);
    int k0;
    k0 = kicks;
    wr(0, 1);
    chk({tag, " kick high"}, gen_reset, 1);
    repeat (dly) @(negedge clk);
    gen_done = 1'b1;
    wait_idle(tag);
    gen_done = 1'b0;
    chk({tag, " kick count"}, kicks - k0, 1);
  endtask

  // Expected results derived from the words the generator delivered since 'first'.
  task automatic check_run(input int first, input string tag);
    logic [SW-1:0] moves [$];
    logic [WW-1:0] wv;
    logic [SW:0] slot;
    logic [31:0] d;
    int n;
    for (int w = first; w < wr_n; w++) begin
      wv = mem[w[7:0]];
      for (int s = 0; s < SL; s++) begin
        slot = wv[s*(SW+1) +: SW+1];
        if (!slot[SW]) moves.push_back(slot[SW-1:0]);
      end
    end
    n = moves.size() > MAXM ? MAXM : moves.size();
    rd(1, d);
    chk({tag, " status"}, d, {moves.size() > MAXM, 15'b0, 16'(n)});
    rd(0, d);
    chk({tag, " ctrl"}, d, 32'd3);
    for (int i = 0; i < n; i++) begin
      rd(16 + i, d);
      chk({tag, " ram"}, d, 32'(moves[i]));
    end
    rd(16 + n, d);
    chk({tag, " terminator"}, d, 0);
  endtask

  initial begin
    logic [31:0] d, v;
    logic [WW-1:0] w;
    int first, p0;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst rden", gen_rden, 0);
    chk("rst kick", gen_reset, 0);
    reset = 1'b0;
    rd(0, d); chk("rst ctrl", d, 0);
    rd(1, d); chk("rst status", d, 0);
    rd(11, d); chk("unmapped 0xB", d, 0);

    for (int k = 1; k <= 8; k++) wr(k + 1, 32'h11111111 * 32'(k));
    chk("bstate low", gen_bstate[31:0], 32'h11111111);
    chk("bstate high", gen_bstate[255:224], 32'h88888888);
    rd(2, d); chk("board rb", d, 32'h11111111);

    first = wr_n;
    w = '0;
    for (int s = 0; s < SL; s++) w[s*(SW+1) +: SW+1] = {1'b1, SW'(0)};
    w[0*(SW+1) +: SW+1] = {1'b0, 18'h00123};
    w[3*(SW+1) +: SW+1] = {1'b0, 18'h3FFFF};
    w[7*(SW+1) +: SW+1] = {1'b0, 18'h00001};
    push(w);
    run(5, "dir");
    check_run(first, "dir");
`ifdef MOVE_LIST_CTRL_PERF_EN
    rd(10, d); chk("perf", d, 18);
    rd(10, d); chk("perf reread", d, 18);
`else
    rd(10, d); chk("perf off", d, 0);
`endif
    wr(16, 32'hDEADBEEF);
    rd(16, d); chk("ram write ignored", d, 32'h123);

    first = wr_n;
    for (int i = 0; i < 7; i++) push(rnd_word(1));
    run($urandom_range(1, 6), "ovf");
    check_run(first, "ovf");

    for (int r = 0; r < 4; r++) begin
      first = wr_n;
      for (int i = 0, n = $urandom_range(0, 4); i < n; i++) push(rnd_word(0));
      run($urandom_range(1, 8), "rnd");
      check_run(first, "rnd");
    end

    p0 = pops;
    wr(0, 1);
    rd(1, d); chk("abort cleared", d, 0);
    repeat (2) @(negedge clk);
    chk("abort in wait", busy, 1);
    wr(0, 0);
    chk("abort idle", busy, 0);
    rd(0, d); chk("abort ctrl", d, 0);
    first = wr_n;
    push(rnd_word(0));
    gen_done = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort no pop", pops - p0, 0);
    gen_done = 1'b0;
    run($urandom_range(1, 4), "restart");
    check_run(first, "restart");

    push(rnd_word(1));
    wr(0, 1);
    gen_done = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (gen_rden) break;
      @(negedge clk);
    end
    chk("pop seen", gen_rden, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid rst busy", busy, 0);
    chk("mid rst rden", gen_rden, 0);
    @(negedge clk);
    reset = 1'b0;
    gen_done = 1'b0;
    rd(1, d); chk("mid rst status", d, 0);
    rd(0, d); chk("mid rst ctrl", d, 0);
    chk("mid rst bstate", gen_bstate, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/move_list_ctrl.md
Name: move_list_ctrl

Overview:
- Avalon-MM slave that sits between the HPS and a legal-move generator.
- Software writes the board state and sets start. The block pulses the generator and drains its FIFO. Each FIFO word holds SLOTS packed move slots; the block unpacks them and writes only the valid moves into an internal result RAM. It then publishes the count, overflow flag and done bit.
- Parametrised successor of the single-shot 8-slot controller: slot count, slot width and RAM depth are generic, and it adds overflow protection, abort, and a proper FSM.

Parameters:
- ADDR_WIDTH, 10, slave word-address width. Result RAM depth = 2**ADDR_WIDTH-16.
- SLOTS, 8, move slots per generator FIFO word.
- SLOT_W, 18, move payload bits per slot. Each slot is SLOT_W+1 bits wide; its MSB is the invalid flag.
- BOARD_BITS, 256, board-state width. Must be a multiple of 32 and at most 256.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- slave_address  in  ADDR_WIDTH  word address
- slave_read  in  1  read strobe
- slave_write  in  1  write strobe
- slave_writedata  in  32  write data
- slave_readdata  out  32  read data, registered, readLatency=1
- gen_reset  out  1  one-cycle start/reset pulse to the generator
- gen_bstate  out  BOARD_BITS  board state, held from registers 0x2 upward
- gen_done  in  1  generator has finished filling its FIFO
- gen_fifo_empty  in  1  generator FIFO empty
- gen_rden  out  1  FIFO pop; data is valid on the cycle after the pop
- gen_fifo_data  in  SLOTS*(SLOT_W+1)  packed slots; slot i occupies [i*(SLOT_W+1) +: SLOT_W+1]
- busy  out  1  FSM is not in IDLE or DONE

Behaviour:
- Reset: FSM goes to IDLE. All registers, count, overflow, done, slave_readdata, gen_reset, gen_rden and busy are 0. RAM contents are undefined.
- Memory map (word addresses):
  - 0x0 control: bit0 start, bit1 done (read-only).
  - 0x1 status: [15:0] count, bit31 overflow. Read-only.
  - 0x2..0x2+BOARD_BITS/32-1 board words. Word 0x2 maps to bstate[31:0].
  - 0xA perf counter (see Optional Feature).
  - Other addresses 0xB..0xF read 0.
  - 0x10+i holds move i, zero-extended to 32 bits.
  - Writes at or above 0x10 are ignored.
- Slave read: slave_readdata updates on the cycle after slave_read. Every read (registers or RAM) has latency 1.
- FSM states:
  - IDLE/DONE: a write of start=1 clears done, count and overflow, then moves to KICK.
  - KICK: gen_reset=1 for exactly one cycle, then WAIT.
  - WAIT: when gen_done=1, go to POP.
  - POP: if gen_fifo_empty, go to TERM. Otherwise gen_rden=1 for one cycle, then LATCH.
  - LATCH: capture gen_fifo_data into the slot register, set slot index=0, go to UNPACK.
  - UNPACK: examine one slot per cycle. If the slot's invalid bit is 0, write its payload to RAM[count] and increment count. After slot SLOTS-1, return to POP.
  - TERM: write 0 to RAM[count] as a terminator, then go to DONE.
  - DONE: done=1. Done stays set until start is written to 0 or restarted.
- Capacity: MAX_MOVES = 2**ADDR_WIDTH-17, leaving one word for the terminator.
  - A valid move arriving when count==MAX_MOVES is dropped and sets overflow=1.
  - Unpacking and popping continue until the FIFO is empty.
- Abort: writing start=0 in any busy state returns to IDLE on the next cycle. gen_rden is deasserted, done stays 0, and count keeps its partial value.
- Simultaneous events:
  - A board-register write during busy is accepted, but gen_bstate is only sampled by the generator at KICK.
  - A start=1 write while busy is ignored.
  - A slave read of the RAM on the same cycle as an internal write returns the old data.
- The RAM is a simple dual-port inferred block: the FSM writes, the slave reads.

Optional Feature:
- Macro MOVE_LIST_CTRL_PERF_EN.
- When defined: a 32-bit cycle counter clears on KICK, increments every cycle while busy, freezes in DONE, and saturates at 0xFFFFFFFF. It is readable at 0xA.
- When undefined: no counter logic is built and 0xA reads 0.

Test Plan:
- Reset asserted mid-UNPACK -> busy=0, gen_rden=0; reg 0x1 reads 0; reg 0x0 reads 0.
- Board words 0x2..0x9 = 0x11111111..0x88888888, then start=1 -> gen_reset high for exactly 1 cycle; gen_bstate[31:0]=0x11111111 and gen_bstate[255:224]=0x88888888.
- One FIFO word with slots 0,3,7 valid (payloads 0x00123, 0x3FFFF, 0x00001), then empty -> RAM 0x10=0x123, 0x11=0x3FFFF, 0x12=0x1, 0x13=0; status=0x00000003; done=1.
- ADDR_WIDTH=6 (MAX_MOVES=47), 7 all-valid FIFO words (56 moves) -> count=47, overflow bit31=1, terminator at 0x3F, done=1.
- Write start=0 during WAIT -> IDLE next cycle; done=0; no gen_rden pulses afterwards. Restart with start=1 -> count clears to 0 and a new gen_reset pulse is issued.
- With MOVE_LIST_CTRL_PERF_EN defined, a run of 1 FIFO word with generator done 5 cycles after KICK -> 0xA reads the exact FSM cycle total (1+5+1+1+8+1+1 = 18 ±0 per the state sequence), and the value is stable on re-read.
